// File: rtl/xor_share_pkg.sv
// Shared definitions for the XOR-package time-sharing scheduler: state
// encoding and default sizing.
package xor_share_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int WIDTH_DEF  = 4;
    localparam int SETTLE_DEF = 2;

    // Holds SETTLE_CYCLES-1 for the full legal range 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// ascending with wrap, returned both one-hot and as an index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // Doubling the vector turns the wrap-around search into a plain shift.
    assign req_dbl = {req, req};
    assign rot     = N_REQ'(req_dbl >> ptr);

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign idx    = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
    assign any    = |req;
    assign winner = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/xor_share_scheduler.sv
// Time-shares one external WIDTH-gate XOR package among N_REQ requesters:
// round-robin grant, hold operands SETTLE_CYCLES, then sample the package.
module xor_share_scheduler
    import xor_share_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       y_out,
    output logic [N_REQ-1:0]       y_valid,
    output logic [WIDTH-1:0]       xor_a,
    output logic [WIDTH-1:0]       xor_b,
    input  logic [WIDTH-1:0]       xor_y,
    output state_e                 state_dbg
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // Handshake: req[k] is a level sampled only while IDLE; gnt[k] stays high
    // from the grant edge until the capture edge; y_valid[k] is a one-cycle
    // strobe with y_out, and needs no acknowledgement.

    state_e           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [IDX_W-1:0] next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // AND-OR mux of the winner's operand slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_a = sel_a | (a_in[k*WIDTH +: WIDTH] & {WIDTH{pick_oh[k]}});
            sel_b = sel_b | (b_in[k*WIDTH +: WIDTH] & {WIDTH{pick_oh[k]}});
        end
    end

    assign next_ptr = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            rr_ptr     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            gnt        <= '0;
            y_valid    <= '0;
            y_out      <= '0;
        end else begin
            y_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt        <= pick_oh;
                        opa_q      <= sel_a;
                        opb_q      <= sel_b;
                        settle_cnt <= CNT_LOAD;
                        rr_ptr     <= next_ptr;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // gnt still identifies the served requester here.
                    y_out   <= xor_y;
                    y_valid <= gnt;
                    gnt     <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign xor_a     = opa_q;
    assign xor_b     = opb_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_xor_share_scheduler.sv
// Bench for xor_share_scheduler: directed scenarios plus random traffic,
// checked against a transaction-level schedule model with a result queue.
module tb_xor_share_scheduler;
    import xor_share_pkg::*;

    localparam int N = 4;
    localparam int W = 4;
    localparam int S = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;

    logic [N-1:0] gnt, y_valid;
    logic [W-1:0] y_out, xor_a, xor_b, xor_y;
    state_e       state_dbg;

    logic [N-1:0] gnt_1, yv_1, gnt_15, yv_15;
    logic [W-1:0] y_1, xa_1, xb_1, xy_1, y_15, xa_15, xb_15, xy_15;
    state_e       st_1, st_15;

    // The bench plays the role of the external XOR packages.
    assign xor_y = xor_a ^ xor_b;
    assign xy_1  = xa_1 ^ xb_1;
    assign xy_15 = xa_15 ^ xb_15;

    xor_share_scheduler #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .y_out(y_out), .y_valid(y_valid), .xor_a(xor_a),
        .xor_b(xor_b), .xor_y(xor_y), .state_dbg(state_dbg)
    );

    xor_share_scheduler #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt_1), .y_out(y_1), .y_valid(yv_1), .xor_a(xa_1),
        .xor_b(xb_1), .xor_y(xy_1), .state_dbg(st_1)
    );

    xor_share_scheduler #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(15)) dut_s15 (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt_15), .y_out(y_15), .y_valid(yv_15), .xor_a(xa_15),
        .xor_b(xb_15), .xor_y(xy_15), .state_dbg(st_15)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    int step_n = 0;

    logic [N+W-1:0] exp_q[$];
    logic [N-1:0]   order_q[$];
    int             order_edge_q[$];

    int           m_ptr;
    bit           m_busy;
    int           m_age;
    logic [N-1:0] m_gnt, m_yv;
    logic [W-1:0] m_y, m_xa, m_xb, m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_age  = 0;
        m_gnt  = '0;
        m_yv   = '0;
        m_y    = '0;
        m_xa   = '0;
        m_xb   = '0;
        m_res  = '0;
        exp_q.delete();
    endtask

    // One service takes S+2 edges: grant edge, S settle edges, capture edge.
    // Requests are looked at only when no service is in flight.
    task automatic model_edge();
        int k;
        m_yv = '0;
        if (m_busy) begin
            m_age++;
            if (m_age == S + 1) begin
                m_yv   = m_gnt;
                m_y    = m_res;
                m_gnt  = '0;
                m_busy = 1'b0;
            end
        end else if (req != '0) begin
            k = -1;
            for (int i = 0; i < N; i++) begin
                if (k < 0 && ((req >> ((m_ptr + i) % N)) & N'(1)) != '0) k = (m_ptr + i) % N;
            end
            m_gnt  = N'(1) << k;
            m_xa   = W'(a_in >> (k * W));
            m_xb   = W'(b_in >> (k * W));
            m_res  = m_xa ^ m_xb;
            m_ptr  = (k + 1) % N;
            m_busy = 1'b1;
            m_age  = 0;
            exp_q.push_back({m_gnt, m_res});
        end
    endtask

    task automatic check_outputs();
        logic [N+W-1:0] e;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("y_out", 32'(y_out), 32'(m_y));
        chk("xor_a", 32'(xor_a), 32'(m_xa));
        chk("xor_b", 32'(xor_b), 32'(m_xb));
        if (y_valid !== '0) begin
            order_q.push_back(y_valid);
            order_edge_q.push_back(step_n);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_result", 32'({y_valid, y_out}), 32'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            step_n++;
            model_edge();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in = (a_in & ~((N*W)'({W{1'b1}}) << (k * W))) | ((N*W)'(a) << (k * W));
        b_in = (b_in & ~((N*W)'({W{1'b1}}) << (k * W))) | ((N*W)'(b) << (k * W));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("state_rst", 32'(state_dbg), 32'(ST_IDLE));
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] fair_exp[5];
    int lat1, lat2, lat15;
    logic [W-1:0] r1, r15;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        fair_exp[0] = 4'b0001;
        fair_exp[1] = 4'b0010;
        fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000;
        fair_exp[4] = 4'b0001;
        @(negedge clk);
        apply_reset();

        // Single request on requester 0.
        req = 4'b0001;
        set_ops(0, 4'hA, 4'h6);
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_xa", 32'(xor_a), 32'hA);
        chk("single_xb", 32'(xor_b), 32'h6);
        req = '0;
        step();
        step();
        chk("single_gnt_held", 32'(gnt), 32'h1);
        step();
        chk("single_yv", 32'(y_valid), 32'h1);
        chk("single_y", 32'(y_out), 32'hC);
        chk("single_gnt_clr", 32'(gnt), 32'h0);
        step();
        chk("single_yv_pulse", 32'(y_valid), 32'h0);
        chk("single_y_hold", 32'(y_out), 32'hC);

        // All requesters held from reset.
        req = 4'b1111;
        apply_reset();
        order_q.delete();
        order_edge_q.delete();
        repeat (20) step();
        req = '0;
        chk("fair_count", 32'(order_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (order_q.size() > i) chk("fair_order", 32'(order_q[i]), 32'(fair_exp[i]));
        end
        for (int i = 1; i < 5; i++) begin
            if (order_edge_q.size() > i) chk("fair_gap", 32'(order_edge_q[i] - order_edge_q[i-1]), 32'd4);
        end
        repeat (6) step();

        // Operands and request withdrawn after the grant.
        req = 4'b0100;
        set_ops(2, 4'h3, 4'h5);
        step();
        chk("chg_gnt", 32'(gnt), 32'h4);
        req = '0;
        set_ops(2, 4'hF, 4'h5);
        step();
        step();
        step();
        chk("chg_yv", 32'(y_valid), 32'h4);
        chk("chg_y", 32'(y_out), 32'h6);

        // Pointer now at 3: requester 3 ahead of 0, issued back-to-back.
        req = 4'b1001;
        step();
        chk("wrap_first", 32'(gnt), 32'h8);
        step();
        step();
        step();
        chk("wrap_first_yv", 32'(y_valid), 32'h8);
        step();
        chk("wrap_second", 32'(gnt), 32'h1);
        req = '0;
        repeat (4) step();

        // Reset in the middle of SETTLE.
        req = 4'b0010;
        step();
        req = '0;
        step();
        chk("mid_state", 32'(state_dbg), 32'(ST_SETTLE));
        apply_reset();
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_xa", 32'(xor_a), 32'h0);
        req = 4'b0011;
        step();
        chk("mid_resume", 32'(gnt), 32'h1);
        req = '0;
        repeat (5) step();

        // Random traffic against the model.
        repeat (300) begin
            req  = N'($urandom_range(0, 15));
            a_in = (N*W)'($urandom);
            b_in = (N*W)'($urandom);
            step();
        end

        // Latency for SETTLE_CYCLES = 1, 2, 15.
        req = '0;
        repeat (20) step();
        lat1 = 0; lat2 = 0; lat15 = 0; r1 = '0; r15 = '0;
        set_ops(0, 4'h5, 4'h9);
        req = 4'b0001;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 1) req = '0;
            if (lat1 == 0 && yv_1 != '0) begin lat1 = e; r1 = y_1; end
            if (lat2 == 0 && y_valid != '0) lat2 = e;
            if (lat15 == 0 && yv_15 != '0) begin lat15 = e; r15 = y_15; end
        end
        chk("lat_s1", 32'(lat1), 32'd3);
        chk("lat_s2", 32'(lat2), 32'd4);
        chk("lat_s15", 32'(lat15), 32'd17);
        chk("lat_s1_y", 32'(r1), 32'hC);
        chk("lat_s15_y", 32'(r15), 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
